button_press_classifier: RTL and testbench

Consumes the debounced edge pulses of one push-button and classifies each gesture as a single click, double click, or long press. While a long press is held, it also emits auto-repeat pulses. Sits directly downstream of the debouncer, in the same clock domain, and drives the UI/control logic with one-cycle event strobes.

---
 rtl/button_pkg.sv | 20 ++
 rtl/terminal_timer.sv | 25 ++
 rtl/button_press_classifier.sv | 130 +++++++++++++
 tb/tb_button_press_classifier.sv | 127 ++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types for the push-button gesture classifier
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        PRESS2,
        HOLD
    } state_t;

    // One strobe per gesture kind; at most one bit is set in any cycle.
    typedef struct packed {
        logic ev_single;
        logic ev_double;
        logic ev_long;
        logic ev_repeat;
    } event_t;

endpackage

// File: rtl/terminal_timer.sv
// rtl/terminal_timer.sv - up-counter with clear/enable and a runtime terminal-count compare
module terminal_timer #(
    parameter int CNT_W = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_tc
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_tc = (cnt_q == i_term);

endmodule

// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - classifies debounced press/release pulses into single, double, long and repeat strobes
module button_press_classifier
    import button_pkg::*;
#(
    parameter int LONG_CNT   = 1000000,
    parameter int GAP_CNT    = 250000,
    parameter int REPEAT_CNT = 100000,
    parameter int CNT_W      = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_onhigh,
    input  logic i_onlow,
    output logic o_single,
    output logic o_double,
    output logic o_long,
    output logic o_repeat,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] LONG_T   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_T    = CNT_W'(GAP_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_T = CNT_W'(REPEAT_CNT - 1);

    state_t           state_q, state_d;
    event_t           ev_q, ev_d;
    logic             busy_q;
    logic             press, release_ev;
    logic             tmr_clr, tmr_en, tmr_tc;
    logic [CNT_W-1:0] tmr_term;

    // Simultaneous press and release pulses cancel each other out.
    assign press      = i_onhigh & ~i_onlow;
    assign release_ev = i_onlow & ~i_onhigh;

    always_comb begin
        tmr_term = '0;
        case (state_q)
            PRESS1:  tmr_term = LONG_T;
            GAP:     tmr_term = GAP_T;
            HOLD:    tmr_term = REPEAT_T;
            default: tmr_term = '0;
        endcase
    end

    terminal_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (tmr_clr),
        .i_en    (tmr_en),
        .i_term  (tmr_term),
        .o_tc    (tmr_tc)
    );

    // Timer is held clear unless a timed state is counting toward its terminal value.
    always_comb begin
        state_d = state_q;
        ev_d    = '0;
        tmr_clr = 1'b1;
        tmr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (press) state_d = PRESS1;
            end
            PRESS1: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                if (release_ev) begin
                    state_d = GAP;
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    state_d      = HOLD;
                    ev_d.ev_long = 1'b1;
                    tmr_clr      = 1'b1;
                end
            end
            GAP: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                if (press) begin
                    state_d = PRESS2;
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    state_d        = IDLE;
                    ev_d.ev_single = 1'b1;
                    tmr_clr        = 1'b1;
                end
            end
            PRESS2: begin
                if (release_ev) begin
                    state_d        = IDLE;
                    ev_d.ev_double = 1'b1;
                end
            end
            HOLD: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                if (release_ev) begin
                    state_d = IDLE;
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    ev_d.ev_repeat = 1'b1;
                    tmr_clr        = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ev_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ev_q    <= ev_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign o_single = ev_q.ev_single;
    assign o_double = ev_q.ev_double;
    assign o_long   = ev_q.ev_long;
    assign o_repeat = ev_q.ev_repeat;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// tb/tb_button_press_classifier.sv - directed bench for button_press_classifier
module tb_button_press_classifier;

    logic i_clk = 1'b0;
    logic i_rst_n, i_onhigh, i_onlow;
    logic o_single, o_double, o_long, o_repeat, o_busy;
    int   checks   = 0;
    int   failures = 0;

    always #5 i_clk = ~i_clk;

    button_press_classifier #(
        .LONG_CNT   (8),
        .GAP_CNT    (6),
        .REPEAT_CNT (4),
        .CNT_W      (4)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_onhigh (i_onhigh),
        .i_onlow  (i_onlow),
        .o_single (o_single),
        .o_double (o_double),
        .o_long   (o_long),
        .o_repeat (o_repeat),
        .o_busy   (o_busy)
    );

    // One active edge with the given inputs; outputs are then sampled 1ns later.
    task automatic tick(input logic hi, input logic lo, input logic rst_n);
        i_onhigh = hi;
        i_onlow  = lo;
        i_rst_n  = rst_n;
        @(posedge i_clk);
        #1;
        i_onhigh = 1'b0;
        i_onlow  = 1'b0;
        i_rst_n  = 1'b1;
    endtask

    // Expected vector order: {single, double, long, repeat, busy}
    task automatic chk(input string tag, input int k, input logic [4:0] exp_v);
        logic [4:0] obs;
        obs = {o_single, o_double, o_long, o_repeat, o_busy};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s after_edge=%0d observed=%b expected=%b", tag, k, obs, exp_v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst_n  = 1'b0;
        i_onhigh = 1'b0;
        i_onlow  = 1'b0;

        // 1: reset held with a press pulse, then quiet / stray release in IDLE
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            chk("reset", k, 5'b00000);
        end
        tick(1'b0, 1'b1, 1'b1);
        chk("idle_onlow", 0, 5'b00000);
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            chk("idle_quiet", k, 5'b00000);
        end

        // 2: single click
        for (int k = 0; k <= 11; k++) begin
            tick(k == 0, k == 3, 1'b1);
            chk("single", k, {k == 9, 1'b0, 1'b0, 1'b0, k < 9});
        end

        // 3: double click
        for (int k = 0; k <= 12; k++) begin
            tick(k == 0 || k == 6, k == 3 || k == 10, 1'b1);
            chk("double", k, {1'b0, k == 10, 1'b0, 1'b0, k < 10});
        end

        // 4: long press with auto-repeat
        for (int k = 0; k <= 25; k++) begin
            tick(k == 0, k == 22, 1'b1);
            chk("long", k, {1'b0, 1'b0, k == 8, k == 12 || k == 16 || k == 20, k < 22});
        end

        // 5a: release on the long terminal edge is a short press
        for (int k = 0; k <= 16; k++) begin
            tick(k == 0, k == 8, 1'b1);
            chk("rel_at_tc", k, {k == 14, 1'b0, 1'b0, 1'b0, k < 14});
        end

        // 5b: second press on the gap terminal edge is a double click
        for (int k = 0; k <= 13; k++) begin
            tick(k == 0 || k == 9, k == 3 || k == 11, 1'b1);
            chk("press_at_tc", k, {1'b0, k == 11, 1'b0, 1'b0, k < 11});
        end

        // 6a: simultaneous pulses in IDLE
        for (int k = 0; k <= 3; k++) begin
            tick(k == 0, k == 0, 1'b1);
            chk("both_idle", k, 5'b00000);
        end

        // 6b: simultaneous pulses in PRESS1 do not count as a release
        for (int k = 0; k <= 13; k++) begin
            tick(k == 0 || k == 2, k == 2 || k == 5, 1'b1);
            chk("both_press1", k, {k == 11, 1'b0, 1'b0, 1'b0, k < 11});
        end

        // 6c: reset during GAP discards the pending single click
        for (int k = 0; k <= 14; k++) begin
            tick(k == 0, k == 3, k != 5);
            chk("rst_gap", k, {1'b0, 1'b0, 1'b0, 1'b0, k < 5});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
